memory_access: RTL



---
 rtl/rv_mem_pkg.sv | 28 ++
 rtl/data_ram.sv | 35 +++
 rtl/memory_access.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// ============================================================================
// Module  : rv_mem_pkg
// Brief   : Load/store funct3 codes and memory-stage FSM state encoding.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package rv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/data_ram.sv
// ============================================================================
// Module  : data_ram
// Brief   : Single-port MEM_DEPTH x 32 RAM, byte-enabled write, 1-cycle read.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module data_ram #(
   parameter int MEM_DEPTH = 1024
) (
   input  logic                         clk,
   input  logic [3:0]                   i_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] i_addr,
   input  logic [31:0]                  i_wdata,
   output logic [31:0]                  o_rdata
);

   // Zero power-up contents keep simulation deterministic; contents are never reset.
   logic [31:0] r_mem [MEM_DEPTH] = '{default: 32'h0};
   logic [31:0] r_rdata;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (i_we[i]) begin
            r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
// ============================================================================
// Module  : memory_access
// Brief   : RISC-V memory stage: load/store FSM, alignment check, load extension.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module memory_access
   import rv_mem_pkg::*;
#(
   parameter int MEM_DEPTH = 1024,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] ALU_result,
   input  logic [31:0]       write_data,
   output logic              busy,
   output logic              done,
   output logic [31:0]       load_data,
   output logic              misaligned
);

   localparam int c_IDX_W = $clog2(MEM_DEPTH);

   state_t             r_state;
   logic [c_IDX_W+1:0] r_addr;
   logic [31:0]        r_wdata;
   logic [2:0]         r_funct3;
   logic               r_busy;
   logic               r_done;
   logic [31:0]        r_load_data;
   logic               r_misaligned;

   logic               w_is_load;
   logic               w_is_store;
   logic               w_f3_ok;
   logic               w_fault;
   logic [c_IDX_W-1:0] w_ram_idx;
   logic [3:0]         w_we;
   logic [31:0]        w_ram_wdata;
   logic [31:0]        w_rdata;
   logic [7:0]         w_byte;
   logic [15:0]        w_half;
   logic [31:0]        w_ext;
   logic               w_unused;

   // Address bits above the RAM index are intentionally ignored (wrap-around).
   assign w_unused = ^ALU_result[ADDR_W-1:c_IDX_W+2];

   always_comb begin
      w_is_load  = MemRead & ~MemWrite;
      w_is_store = MemWrite & ~MemRead;
      w_f3_ok    = 1'b0;
      if (w_is_load) begin
         w_f3_ok = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      end else if (w_is_store) begin
         w_f3_ok = funct3 inside {F3_SB, F3_SH, F3_SW};
      end
      w_fault = w_f3_ok &
                (((funct3[1:0] == 2'b01) & ALU_result[0]) |
                 ((funct3[1:0] == 2'b10) & (|ALU_result[1:0])));
   end

   // The read is launched at the accept edge so data is ready during READ.
   assign w_ram_idx = (r_state == S_IDLE) ? ALU_result[c_IDX_W+1:2] : r_addr[c_IDX_W+1:2];

   always_comb begin
      w_we        = 4'b0000;
      w_ram_wdata = r_wdata;
      if ((r_state == S_WRITE) && !reset) begin
         case (r_funct3)
            F3_SB: begin
               w_we        = 4'b0001 << r_addr[1:0];
               w_ram_wdata = {4{r_wdata[7:0]}};
            end
            F3_SH: begin
               w_we        = r_addr[1] ? 4'b1100 : 4'b0011;
               w_ram_wdata = {2{r_wdata[15:0]}};
            end
            default: w_we = 4'b1111;
         endcase
      end
   end

   data_ram #(
      .MEM_DEPTH (MEM_DEPTH)
   ) u_data_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_ram_idx),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_byte = 8'(w_rdata >> {r_addr[1:0], 3'b000});
      w_half = r_addr[1] ? w_rdata[31:16] : w_rdata[15:0];
      case (r_funct3)
         F3_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
         F3_LH:   w_ext = {{16{w_half[15]}}, w_half};
         F3_LBU:  w_ext = {24'h0, w_byte};
         F3_LHU:  w_ext = {16'h0, w_half};
         default: w_ext = w_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_load_data  <= 32'h0;
         r_misaligned <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= 32'h0;
         r_funct3     <= 3'b000;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_addr       <= ALU_result[c_IDX_W+1:0];
                  r_wdata      <= write_data;
                  r_funct3     <= funct3;
                  r_misaligned <= w_fault;
                  r_busy       <= 1'b1;
                  if (w_is_load && w_f3_ok && !w_fault) begin
                     r_state <= S_READ;
                  end else if (w_is_store && w_f3_ok && !w_fault) begin
                     r_state <= S_WRITE;
                     r_done  <= 1'b1;
                  end else begin
                     // No-ops and faults still answer one cycle after acceptance.
                     r_state <= S_RESP;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               r_state     <= S_RESP;
               r_done      <= 1'b1;
               r_load_data <= w_ext;
            end
            S_WRITE, S_RESP: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign load_data  = r_load_data;
   assign misaligned = r_misaligned;

endmodule

`default_nettype wire
